bus_endpoint: RTL and testbench
===============================

# bus_endpoint

Device-side endpoint for the shared bus served by `bs_gnrtr_n_rbtr`; one instance per device, so `drvrs` instances per system. It is the other end of the bus `pndng/pop/D_pop` and `push/D_push` handshakes. On the transmit side it buffers host packets and presents them to the arbiter. On the receive side it filters bus deliveries by destination ID and buffers accepted packets for the host. The verification environment uses it as the RTL reference device model.

## Interface
Parameters:
- `pckg_sz`, 32: packet width in bits; bits `[pckg_sz-1 -: 8]` hold the destination ID.
- `depth`, 4: entries per FIFO, power of two, ≥2.
- `id`, 0: this device's 8-bit ID.
- `broadcast`, 8'hFF: destination ID accepted by every device.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pndng`  out  1  TX FIFO not empty (request to arbiter).
- `D_pop`  out  pckg_sz  TX FIFO head, first-word fall-through.
- `pop`  in  1  arbiter consumes `D_pop` this cycle.
- `push`  in  1  bus delivers `D_push` this cycle.
- `D_push`  in  pckg_sz  delivered packet.
- `tx_push`  in  1  host writes `tx_data`.
- `tx_data`  in  pckg_sz  host packet to send.
- `tx_full`  out  1  TX FIFO full.
- `rx_valid`  out  1  RX FIFO not empty.
- `rx_data`  out  pckg_sz  RX FIFO head, first-word fall-through.
- `rx_pop`  in  1  host consumes `rx_data`.

## Operation
- TX path:
  - `tx_push` with `tx_full`=0 writes `tx_data` at the tail.
  - `tx_push` with `tx_full`=1 is dropped, except when `pop` is also asserted in the same cycle; then the write is accepted and the count is unchanged.
  - `pop` with the FIFO empty is ignored: pointers hold and nothing underflows.
- RX path:
  - On `push`=1 the block decodes `dest = D_push[pckg_sz-1 -: 8]`.
  - The packet is accepted if `dest==id` or `dest==broadcast`; any other destination is discarded silently.
  - An accepted packet is written if the RX FIFO is not full, or if it is full and `rx_pop`=1 in the same cycle.
  - Otherwise the accepted packet is lost (see Configuration).
- `rx_pop` with the RX FIFO empty is ignored.
- Both FIFOs use `$clog2(depth)+1`-bit read/write pointers. The pointers wrap modulo 2·depth.
  - Full: MSBs differ and the low bits are equal.
  - Empty: pointers are equal.
- No state machine beyond the FIFO pointers. The TX and RX paths are fully independent and may both act in the same cycle.

## Timing
- Reset (`reset`=0, asynchronous) clears all pointers immediately.
- Output values during and after reset:
  - `pndng`=0, `tx_full`=0, `rx_valid`=0.
  - `D_pop` and `rx_data` read the slot-0 contents. Storage is not cleared, so these are don't-care while the FIFO is empty.
- Reset asserted mid-transfer discards all buffered packets. An in-flight `pop` or `push` in that cycle is lost.
- `tx_push` at edge t makes `pndng`=1 after edge t (visible in cycle t+1).
- `pop` at edge t: the head advances after edge t. The next packet, or `pndng`=0, is visible in cycle t+1. `D_pop` is valid whenever `pndng`=1.
- Accepted `push` at edge t makes `rx_valid`=1 in cycle t+1. Write-to-read latency is 1 cycle.
- `rx_pop` at edge t advances the RX head in cycle t+1.
- Flags are combinational from the pointers; the packet data path contains no combinational path from input to output.

## Configuration
- `BUS_ENDPOINT_DROP_CNT_EN` defined:
  - Adds output `drop_cnt` (16 bits). It increments by 1 for each accepted-ID packet lost to RX full, and saturates at 16'hFFFF.
  - Adds output `tx_ovf` (1 bit), sticky high after any dropped `tx_push`.
  - Both are cleared by reset.
- Not defined: neither port exists; drops are silent.

## Structure
- Shared package `bus_endpoint_pkg`:
  - `typedef logic [7:0] dev_id_t`.
  - Localparam `BCAST_ID = 8'hFF`.
  - Function `dest_of(pkt)` returning the top 8 bits.
- Sub-module `endpoint_fifo`, parameterized by width and depth:
  - Push/pop/full/empty/head with first-word fall-through.
  - Simultaneous push and pop when full is allowed.
  - Instantiated twice (TX, RX).
- The top level holds only the ID filter and the optional drop logic.

## Test plan
All scenarios use `id`=2, `pckg_sz`=32, `depth`=4.
- Reset:
  - Drive `reset`=0 mid-cycle with 3 TX entries queued. Required: `pndng`, `tx_full` and `rx_valid` go 0 immediately.
  - After release, the queue stays empty.
- TX ordering: `tx_push` 32'h0200_0001..32'h0200_0004 → `tx_full`=1. Pop ×4 returns the same order on `D_pop`; `pndng`=0 after the 4th pop.
- TX overflow:
  - With TX full, a 5th `tx_push` is dropped.
  - A simultaneous `tx_push` + `pop` when full is accepted; `tx_full` stays 1.
  - `tx_ovf`=1 when the macro is defined.
- RX filter: push 32'h0200_00AA (accept), 32'h0300_00BB (discard) and 32'hFF00_00CC (broadcast, accept). Required: `rx_data` yields AA then CC; `rx_valid`=1 one cycle after the first push.
- RX full:
  - Fill RX with 4 packets, then push 32'h0200_0005 without `rx_pop`. Required: the packet is lost; `drop_cnt`=1 when the macro is defined.
  - Repeat with `rx_pop`=1 in the same cycle. Required: the packet is stored.
- Empty pops: assert `pop` and `rx_pop` on empty FIFOs for 3 cycles. Required: no flag change, and a subsequent single push reads back correctly.

Source files
------------

// File: rtl/bus_endpoint_pkg.sv
// bus_endpoint_pkg: shared types, constants and the destination decoder for
// the bus endpoint slice.
package bus_endpoint_pkg;

    // Device identifier carried in the top byte of every packet.
    typedef logic [7:0] dev_id_t;

    // Destination ID accepted by every device on the bus.
    localparam dev_id_t BCAST_ID = 8'hFF;

    // Widest packet the decoder handles; packets are zero-extended to this width.
    localparam int PKT_MAX = 256;

    // Return the top byte of a packet of width sz that was zero-extended to PKT_MAX bits.
    function automatic dev_id_t dest_of(input logic [PKT_MAX-1:0] pkt, input int unsigned sz);
        return dev_id_t'(pkt >> (sz - 32'd8));
    endfunction

endpackage

// File: rtl/bus_endpoint_if.sv
// bus_endpoint_if: arbiter-facing handshake signals of one endpoint.
// master = arbiter side (consumes pndng/D_pop, delivers push/D_push),
// slave  = endpoint side.
interface bus_endpoint_if #(
    parameter int pckg_sz = 32
);
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );
endinterface

// File: rtl/bus_endpoint_fifo.sv
// endpoint_fifo: first-word fall-through FIFO with extended-pointer full/empty
// detection. A write is accepted while full when a read happens in the same
// cycle; a read on an empty FIFO is ignored. Storage is not reset.
module endpoint_fifo #(
    parameter int width = 32,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] head
);
    localparam int AW = $clog2(depth);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [width-1:0] mem_r [depth];
    logic             wr_en_s;
    logic             rd_en_s;

    // Status flags straight from the pointers, and qualified read/write enables.
    always_comb begin
        empty   = (wr_ptr_r == rd_ptr_r);
        full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        rd_en_s = pop & ~empty;
        wr_en_s = push & (~full | pop);
    end

    // Pointer update; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write at the tail slot.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Head slot is presented directly (fall-through).
    assign head = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/bus_endpoint.sv
// bus_endpoint: device-side endpoint of the shared bus. A TX FIFO buffers
// host packets for the arbiter; an RX FIFO buffers bus deliveries whose
// destination byte matches this device's ID or the broadcast ID.
// Optional feature macro: BUS_ENDPOINT_DROP_CNT_EN adds the drop_cnt
// (saturating RX loss counter) and tx_ovf (sticky TX overflow) outputs.
module bus_endpoint
    import bus_endpoint_pkg::*;
#(
    parameter int      pckg_sz   = 32,
    parameter int      depth     = 4,
    parameter int      id        = 0,
    parameter dev_id_t broadcast = BCAST_ID
) (
    input  logic               clk,
    input  logic               reset,
    bus_endpoint_if.slave      bus,
    input  logic               tx_push,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_pop
`ifdef BUS_ENDPOINT_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt,
    output logic               tx_ovf
`endif
);
    localparam dev_id_t MY_ID = dev_id_t'(id);

    logic [PKT_MAX-1:0] push_ext_s;
    dev_id_t            dest_s;
    logic               accept_s;
    logic               rx_push_s;
    logic               tx_empty_s;
    logic               rx_empty_s;
    logic               rx_full_s;
    logic [pckg_sz-1:0] tx_head_s;

    // Destination filter: accept packets addressed to this device or to everyone.
    always_comb begin
        push_ext_s = PKT_MAX'(bus.D_push);
        dest_s     = dest_of(push_ext_s, pckg_sz);
        accept_s   = (dest_s == MY_ID) || (dest_s == broadcast);
        rx_push_s  = bus.push & accept_s;
    end

    endpoint_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .din   (tx_data),
        .pop   (bus.pop),
        .full  (tx_full),
        .empty (tx_empty_s),
        .head  (tx_head_s)
    );

    endpoint_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push_s),
        .din   (bus.D_push),
        .pop   (rx_pop),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .head  (rx_data)
    );

    assign bus.pndng = ~tx_empty_s;
    assign bus.D_pop = tx_head_s;
    assign rx_valid  = ~rx_empty_s;

`ifdef BUS_ENDPOINT_DROP_CNT_EN
    logic        rx_lost_s;
    logic        tx_drop_s;
    logic [15:0] drop_cnt_r;
    logic        tx_ovf_r;

    // Loss events: an accepted packet with no room, or a host write with no room.
    always_comb begin
        rx_lost_s = rx_push_s & rx_full_s & ~rx_pop;
        tx_drop_s = tx_push & tx_full & ~bus.pop;
    end

    // Saturating RX loss counter and sticky TX overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_r <= 16'h0000;
            tx_ovf_r   <= 1'b0;
        end else begin
            if (rx_lost_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end
            if (tx_drop_s) begin
                tx_ovf_r <= 1'b1;
            end
        end
    end

    assign drop_cnt = drop_cnt_r;
    assign tx_ovf   = tx_ovf_r;
`else
    // RX overflow is silent in this build; the full flag has no consumer.
    logic unused_rx_full_s;
    assign unused_rx_full_s = rx_full_s;
`endif

endmodule

// File: tb/tb_bus_endpoint.sv
// tb_bus_endpoint: directed stimulus with a queue scoreboard. Expected TX and
// RX packets are queued when issued; a monitor on the falling edge pops and
// compares whenever a pop is presented against a non-empty FIFO.
module tb_bus_endpoint;
    logic        clk = 1'b0;
    logic        reset;
    logic        tx_push;
    logic [31:0] tx_data;
    logic        tx_full;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_pop;
`ifdef BUS_ENDPOINT_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic        tx_ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] tx_exp_q[$];
    logic [31:0] rx_exp_q[$];

    always #5 clk = ~clk;

    bus_endpoint_if #(.pckg_sz(32)) bus ();

    bus_endpoint #(
        .pckg_sz   (32),
        .depth     (4),
        .id        (2),
        .broadcast (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .tx_push  (tx_push),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_pop   (rx_pop)
`ifdef BUS_ENDPOINT_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt),
        .tx_ovf   (tx_ovf)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tx_push     = 1'b0;
        tx_data     = 32'h0000_0000;
        rx_pop      = 1'b0;
        bus.pop     = 1'b0;
        bus.push    = 1'b0;
        bus.D_push  = 32'h0000_0000;
    endtask

    // Scoreboard monitor: compare each consumed head against the expected queue.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.pop === 1'b1 && bus.pndng === 1'b1) begin
                if (tx_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %h expected nothing", bus.D_pop);
                end else begin
                    chk("tx_D_pop", bus.D_pop, tx_exp_q.pop_front());
                end
            end
            if (rx_pop === 1'b1 && rx_valid === 1'b1) begin
                if (rx_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %h expected nothing", rx_data);
                end else begin
                    chk("rx_data", rx_data, rx_exp_q.pop_front());
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        idle();
        cyc();
        cyc();
        chk("reset_pndng", {31'd0, bus.pndng}, 32'd0);
        chk("reset_tx_full", {31'd0, tx_full}, 32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
`ifdef BUS_ENDPOINT_DROP_CNT_EN
        chk("reset_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        chk("reset_tx_ovf", {31'd0, tx_ovf}, 32'd0);
`endif
        reset = 1'b1;
        cyc();

        // Mid-cycle reset with 3 TX entries and 1 RX entry buffered.
        for (int i = 0; i < 3; i++) begin
            tx_push = 1'b1;
            tx_data = 32'h0200_00A1 + 32'(i);
            if (i == 0) begin
                bus.push   = 1'b1;
                bus.D_push = 32'h0200_0077;
            end else begin
                bus.push = 1'b0;
            end
            cyc();
        end
        idle();
        chk("pre_reset_pndng", {31'd0, bus.pndng}, 32'd1);
        chk("pre_reset_rx_valid", {31'd0, rx_valid}, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_pndng", {31'd0, bus.pndng}, 32'd0);
        chk("async_reset_tx_full", {31'd0, tx_full}, 32'd0);
        chk("async_reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        chk("post_reset_pndng", {31'd0, bus.pndng}, 32'd0);
        chk("post_reset_rx_valid", {31'd0, rx_valid}, 32'd0);

        // TX ordering: fill, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            tx_push = 1'b1;
            tx_data = 32'h0200_0000 + 32'(i);
            tx_exp_q.push_back(32'h0200_0000 + 32'(i));
            cyc();
            if (i == 1) begin
                chk("tx_first_pndng", {31'd0, bus.pndng}, 32'd1);
            end
        end
        idle();
        chk("tx_full_after_4", {31'd0, tx_full}, 32'd1);
        bus.pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
        end
        idle();
        chk("tx_drained_pndng", {31'd0, bus.pndng}, 32'd0);
        chk("tx_drained_full", {31'd0, tx_full}, 32'd0);
`ifdef BUS_ENDPOINT_DROP_CNT_EN
        chk("tx_ovf_clear", {31'd0, tx_ovf}, 32'd0);
`endif

        // TX overflow: drop when full, accept when full with simultaneous pop.
        for (int i = 1; i <= 4; i++) begin
            tx_push = 1'b1;
            tx_data = 32'h0200_0010 + 32'(i);
            tx_exp_q.push_back(32'h0200_0010 + 32'(i));
            cyc();
        end
        tx_push = 1'b1;
        tx_data = 32'h0200_00EE;
        cyc();
        idle();
        chk("tx_full_after_drop", {31'd0, tx_full}, 32'd1);
`ifdef BUS_ENDPOINT_DROP_CNT_EN
        chk("tx_ovf_set", {31'd0, tx_ovf}, 32'd1);
`endif
        tx_push = 1'b1;
        tx_data = 32'h0200_0015;
        bus.pop = 1'b1;
        tx_exp_q.push_back(32'h0200_0015);
        cyc();
        idle();
        chk("tx_full_push_pop", {31'd0, tx_full}, 32'd1);
        bus.pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
        end
        idle();
        chk("tx_ovf_drained_pndng", {31'd0, bus.pndng}, 32'd0);

        // RX filter: own ID accepted, foreign ID discarded, broadcast accepted.
        bus.push   = 1'b1;
        bus.D_push = 32'h0200_00AA;
        rx_exp_q.push_back(32'h0200_00AA);
        cyc();
        idle();
        chk("rx_valid_latency", {31'd0, rx_valid}, 32'd1);
        bus.push   = 1'b1;
        bus.D_push = 32'h0300_00BB;
        cyc();
        bus.D_push = 32'hFF00_00CC;
        rx_exp_q.push_back(32'hFF00_00CC);
        cyc();
        idle();
        rx_pop = 1'b1;
        cyc();
        cyc();
        idle();
        chk("rx_filter_empty", {31'd0, rx_valid}, 32'd0);

        // RX full: lost without rx_pop, stored with rx_pop.
        for (int i = 0; i < 4; i++) begin
            bus.push   = 1'b1;
            bus.D_push = 32'h0200_0010 + 32'(i);
            rx_exp_q.push_back(32'h0200_0010 + 32'(i));
            cyc();
        end
        idle();
        chk("rx_full_valid", {31'd0, rx_valid}, 32'd1);
`ifdef BUS_ENDPOINT_DROP_CNT_EN
        chk("drop_cnt_zero", {16'd0, drop_cnt}, 32'd0);
`endif
        bus.push   = 1'b1;
        bus.D_push = 32'h0200_0005;
        cyc();
        idle();
`ifdef BUS_ENDPOINT_DROP_CNT_EN
        chk("drop_cnt_one", {16'd0, drop_cnt}, 32'd1);
`endif
        bus.push   = 1'b1;
        bus.D_push = 32'h0300_0006;
        cyc();
        idle();
`ifdef BUS_ENDPOINT_DROP_CNT_EN
        chk("drop_cnt_foreign", {16'd0, drop_cnt}, 32'd1);
`endif
        bus.push   = 1'b1;
        bus.D_push = 32'h0200_0005;
        rx_pop     = 1'b1;
        rx_exp_q.push_back(32'h0200_0005);
        cyc();
        idle();
`ifdef BUS_ENDPOINT_DROP_CNT_EN
        chk("drop_cnt_push_pop", {16'd0, drop_cnt}, 32'd1);
`endif
        rx_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
        end
        idle();
        chk("rx_full_drained", {31'd0, rx_valid}, 32'd0);

        // Pops on empty FIFOs change nothing.
        bus.pop = 1'b1;
        rx_pop  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("empty_pop_pndng", {31'd0, bus.pndng}, 32'd0);
            chk("empty_pop_rx_valid", {31'd0, rx_valid}, 32'd0);
            chk("empty_pop_tx_full", {31'd0, tx_full}, 32'd0);
        end
        idle();
        tx_push    = 1'b1;
        tx_data    = 32'h0200_0099;
        bus.push   = 1'b1;
        bus.D_push = 32'hFF00_0042;
        tx_exp_q.push_back(32'h0200_0099);
        rx_exp_q.push_back(32'hFF00_0042);
        cyc();
        idle();
        chk("single_pndng", {31'd0, bus.pndng}, 32'd1);
        chk("single_rx_valid", {31'd0, rx_valid}, 32'd1);
        bus.pop = 1'b1;
        rx_pop  = 1'b1;
        cyc();
        idle();
        chk("single_drained_pndng", {31'd0, bus.pndng}, 32'd0);
        chk("single_drained_rx_valid", {31'd0, rx_valid}, 32'd0);

        cyc();
        chk("tx_queue_left", 32'(tx_exp_q.size()), 32'd0);
        chk("rx_queue_left", 32'(rx_exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
